div_u: RTL and testbench

Unsigned 16-bit sequential divider for the UART calculator ALU; the inverse operation of the unsigned shift-add multiplier, sharing its start/dtype/done handshake. It runs a restoring shift-subtract algorithm, one quotient bit per clock, and returns quotient and remainder packed into one 32-bit result. It sits beside the multiplier under the ALU dispatcher, which selects the operation by `dtype`.

---
 rtl/alu_defs.sv | 18 +
 rtl/div_u_step.sv | 26 ++
 rtl/div_u.sv | 120 ++++++++++++
 tb/tb_div_u.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/alu_defs.sv
// Shared definitions for the UART calculator ALU: operation codes, operand width
// and the packed divider result payload.
package alu_defs;

  localparam logic [3:0] DTYPE_MUL_U = 4'h1;
  localparam logic [3:0] DTYPE_DIV_U = 4'h3;

  localparam int unsigned OP_W   = 16;
  localparam int unsigned ITER_N = 16;
  localparam int unsigned CNT_W  = $clog2(ITER_N + 1);

  // Remainder occupies the upper half, quotient the lower half.
  typedef struct packed {
    logic [OP_W-1:0] rem;
    logic [OP_W-1:0] quo;
  } div_res_t;

endpackage

// File: rtl/div_u_step.sv
// One restoring shift-subtract iteration: shifts the next dividend bit into the
// partial remainder and emits one quotient bit.
module div_u_step
  import alu_defs::*;
(
  input  logic [OP_W-1:0] r,
  input  logic [OP_W-1:0] q,
  input  logic [OP_W-1:0] d,
  output logic [OP_W-1:0] r_next,
  output logic [OP_W-1:0] q_next
);

  logic [OP_W:0] t;

  always_comb begin
    t = {r, q[OP_W-1]} - {1'b0, d};
    if (!t[OP_W]) begin
      r_next = t[OP_W-1:0];
      q_next = {q[OP_W-2:0], 1'b1};
    end else begin
      r_next = {r[OP_W-2:0], q[OP_W-1]};
      q_next = {q[OP_W-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_u.sv
// Unsigned 16/16 sequential restoring divider, one quotient bit per clock.
// Optional macro DIV_U_ZERO_EARLY_EN short-circuits divide-by-zero straight to FIN.
module div_u
  import alu_defs::*;
(
  input  logic              clk,
  input  logic              n_rst,
  input  logic              start,
  input  logic [3:0]        dtype,
  input  logic [OP_W-1:0]   dividend,
  input  logic [OP_W-1:0]   divisor,
  output logic [2*OP_W-1:0] result,
  output logic              done,
  output logic              div_zero
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_FIN
  } state_t;

  state_t           state, state_n;
  logic [OP_W-1:0]  r, r_n;
  logic [OP_W-1:0]  q, q_n;
  logic [OP_W-1:0]  d, d_n;
  logic [CNT_W-1:0] count, count_n;
  div_res_t         res, res_n;
  logic             done_n;
  logic             div_zero_n;
  logic [OP_W-1:0]  r_step;
  logic [OP_W-1:0]  q_step;

  div_u_step u_step (
    .r      (r),
    .q      (q),
    .d      (d),
    .r_next (r_step),
    .q_next (q_step)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      r        <= '0;
      q        <= '0;
      d        <= '0;
      count    <= '0;
      res      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      state    <= state_n;
      r        <= r_n;
      q        <= q_n;
      d        <= d_n;
      count    <= count_n;
      res      <= res_n;
      done     <= done_n;
      div_zero <= div_zero_n;
    end
  end

  // Next-state and datapath; done defaults low so it pulses for one cycle.
  always_comb begin
    state_n    = state;
    r_n        = r;
    q_n        = q;
    d_n        = d;
    count_n    = count;
    res_n      = res;
    done_n     = 1'b0;
    div_zero_n = div_zero;

    case (state)
      S_IDLE: begin
        if (start && (dtype == DTYPE_DIV_U)) begin
          r_n     = '0;
          q_n     = dividend;
          d_n     = divisor;
          count_n = CNT_W'(ITER_N);
          state_n = S_CALC;
`ifdef DIV_U_ZERO_EARLY_EN
          // Preload the natural divide-by-zero answer and skip the iterations.
          if (divisor == '0) begin
            r_n     = dividend;
            q_n     = '1;
            count_n = '0;
            state_n = S_FIN;
          end
`else
`endif
        end
      end

      S_CALC: begin
        r_n     = r_step;
        q_n     = q_step;
        count_n = count - CNT_W'(1);
        if (count == CNT_W'(1)) begin
          state_n = S_FIN;
        end
      end

      S_FIN: begin
        res_n      = '{rem: r, quo: q};
        done_n     = 1'b1;
        div_zero_n = (d == '0);
        state_n    = S_IDLE;
      end

      default: begin
        state_n = S_IDLE;
      end
    endcase
  end

  assign result = res;

endmodule

// File: tb/tb_div_u.sv
// Self-checking bench for div_u: directed cases plus randomized operands
// against an arithmetic quotient/remainder model.
module tb_div_u;

  logic        clk;
  logic        n_rst;
  logic        start;
  logic [3:0]  dtype;
  logic [15:0] dividend;
  logic [15:0] divisor;
  logic [31:0] result;
  logic        done;
  logic        div_zero;

  int checks = 0;
  int errors = 0;

`ifdef DIV_U_ZERO_EARLY_EN
  localparam int ZERO_LAT = 1;
`else
  localparam int ZERO_LAT = 17;
`endif
  localparam int NORM_LAT = 17;

  div_u dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .start    (start),
    .dtype    (dtype),
    .dividend (dividend),
    .divisor  (divisor),
    .result   (result),
    .done     (done),
    .div_zero (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [15:0] n, input logic [15:0] dv);
    logic [15:0] qq;
    logic [15:0] rr;
    if (dv == 16'd0) begin
      qq = 16'hFFFF;
      rr = n;
    end else begin
      qq = n / dv;
      rr = n % dv;
    end
    return {rr, qq};
  endfunction

  // Present a request now (posedge+1) so the next rising edge is E0.
  task automatic launch(input logic [3:0] dt, input logic [15:0] n, input logic [15:0] dv);
    start    = 1'b1;
    dtype    = dt;
    dividend = n;
    divisor  = dv;
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  // Counts edges after E0 until done is seen; optionally re-pokes start mid-flight.
  task automatic wait_done(input int poke, output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (poke != 0 && k == poke) begin
        start    = 1'b1;
        dtype    = 4'h3;
        dividend = 16'd50;
        divisor  = 16'd5;
      end else if (poke != 0 && k == poke + 1) begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
      if (done) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic run_op(input string tag, input logic [15:0] n, input logic [15:0] dv);
    int lat;
    launch(4'h3, n, dv);
    wait_done(0, lat);
    chk({tag, "_lat"}, 32'(lat), 32'((dv == 16'd0) ? ZERO_LAT : NORM_LAT));
    chk({tag, "_res"}, result, model(n, dv));
    chk({tag, "_dz"}, 32'(div_zero), 32'(dv == 16'd0));
    @(posedge clk);
    #1;
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_hold"}, result, model(n, dv));
  endtask

  initial begin
    int lat;
    int seen;
    logic [15:0] rn;
    logic [15:0] rd;

    n_rst    = 1'b0;
    start    = 1'b0;
    dtype    = 4'h0;
    dividend = 16'd0;
    divisor  = 16'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", result, 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_dz", 32'(div_zero), 32'd0);
    n_rst = 1'b1;
    @(posedge clk);
    #1;

    run_op("d100_7", 16'd100, 16'd7);
    chk("d100_7_abs", result, 32'h0002_000E);
    run_op("ffff_1", 16'hFFFF, 16'd1);
    chk("ffff_1_abs", result, 32'h0000_FFFF);
    run_op("ffff_ffff", 16'hFFFF, 16'hFFFF);
    chk("ffff_ffff_abs", result, 32'h0000_0001);
    run_op("d5_9", 16'd5, 16'd9);
    chk("d5_9_abs", result, 32'h0005_0000);
    run_op("dzero", 16'h1234, 16'd0);
    chk("dzero_abs", result, 32'h1234_FFFF);

    // Wrong operation code must not start anything.
    launch(4'h1, 16'd77, 16'd3);
    seen = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("mul_dtype_no_done", 32'(seen), 32'd0);
    chk("mul_dtype_result", result, 32'h1234_FFFF);

    // Request during CALC is ignored.
    launch(4'h3, 16'd1000, 16'd3);
    wait_done(5, lat);
    chk("busy_lat", 32'(lat), 32'(NORM_LAT));
    chk("busy_res", result, model(16'd1000, 16'd3));
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("busy_no_second", 32'(seen), 32'd0);

    // Reset at iteration 8.
    launch(4'h3, 16'hABCD, 16'h0013);
    repeat (7) @(posedge clk);
    #1;
    n_rst = 1'b0;
    #1;
    chk("midrst_result", result, 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_dz", 32'(div_zero), 32'd0);
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    seen = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (done) seen++;
    end
    chk("midrst_no_done", 32'(seen), 32'd0);
    run_op("d9_3", 16'd9, 16'd3);
    chk("d9_3_abs", result, 32'h0000_0003);

    // Back-to-back: second start presented in the done cycle.
    launch(4'h3, 16'd200, 16'd10);
    wait_done(0, lat);
    chk("b2b1_lat", 32'(lat), 32'(NORM_LAT));
    chk("b2b1_res", result, 32'h0000_0014);
    launch(4'h3, 16'd7, 16'd2);
    chk("b2b1_pulse", 32'(done), 32'd0);
    wait_done(0, lat);
    chk("b2b2_lat", 32'(lat), 32'(NORM_LAT));
    chk("b2b2_res", result, 32'h0001_0003);
    @(posedge clk);
    #1;
    chk("b2b2_pulse", 32'(done), 32'd0);

    // Randomized operands, with small and zero divisors mixed in.
    for (int i = 0; i < 24; i++) begin
      rn = 16'($urandom);
      case (i % 4)
        0: rd = 16'($urandom);
        1: rd = 16'($urandom_range(1, 15));
        2: rd = (i % 8 == 2) ? 16'd0 : 16'($urandom_range(1, 255));
        default: rd = 16'($urandom_range(0, 3));
      endcase
      run_op("rand", rn, rd);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
